// File: rtl/header_buffer_pkg.sv
// Shared state encoding, header geometry and helpers for the header buffer.
package header_buffer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT      = 3'd2,
    ST_FOUND     = 3'd3,
    ST_EXHAUSTED = 3'd4
  } state_t;

  localparam int HDR_BYTES = 80;
  localparam int NONCE_OFS = 76;
  localparam int HDR_BITS  = HDR_BYTES * 8;

  // Mask bit for a byte index; out-of-range indices select nothing.
  function automatic logic [HDR_BYTES-1:0] byte_onehot(input logic [7:0] idx);
    logic [HDR_BYTES-1:0] v;
    v = {HDR_BYTES{1'b0}};
    if (idx < 8'(HDR_BYTES)) begin
      v[idx[6:0]] = 1'b1;
    end else begin
      v = {HDR_BYTES{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/header_buffer.sv
// Collects an 80-byte block header, then offers it to a hash core while
// stepping the nonce until a hit is reported or the nonce range runs out.
module header_buffer
  import header_buffer_pkg::*;
#(
  parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         write_enable,
  input  logic [7:0]   rx_data,
  input  logic [7:0]   byte_cnt,
  input  logic         packet_done,
  input  logic         hash_ready,
  input  logic         hash_done,
  input  logic         valid_hash,
  output logic         header_valid,
  output logic [639:0] header,
  output logic [31:0]  nonce,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         hdr_err
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_bytes [HDR_BYTES];
  logic [HDR_BYTES-1:0]  r_mask;
  logic [HDR_BYTES-1:0]  w_onehot;
  logic [HDR_BYTES-1:0]  w_mask_eff;
  logic [31:0]           r_nonce;
  logic                  r_header_valid;
  logic                  r_busy;
  logic                  r_found;
  logic                  r_exhausted;
  logic                  r_hdr_err;
  logic                  w_store;
  logic                  w_restart;
  logic                  w_nonce_inc;
  logic                  w_hdr_err;
  logic [HDR_BITS-1:0]   w_header;

  // A write landing with packet_done still counts toward completeness.
  assign w_onehot   = write_enable ? byte_onehot(byte_cnt) : {HDR_BYTES{1'b0}};
  assign w_mask_eff = r_mask | w_onehot;

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_restart   = 1'b0;
    w_nonce_inc = 1'b0;
    w_hdr_err   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_store = write_enable;
        if (packet_done) begin
          if (&w_mask_eff) begin
            w_state_nxt = ST_ISSUE;
          end else begin
            w_hdr_err = 1'b1;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (hash_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (hash_done) begin
          if (valid_hash) begin
            w_state_nxt = ST_FOUND;
          end else if (r_nonce == NONCE_LIMIT) begin
            w_state_nxt = ST_EXHAUSTED;
          end else begin
            w_state_nxt = ST_ISSUE;
            w_nonce_inc = 1'b1;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_FOUND, ST_EXHAUSTED: begin
        if (write_enable) begin
          w_state_nxt = ST_IDLE;
          w_store     = 1'b1;
          w_restart   = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Byte store, completeness mask and nonce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HDR_BYTES; i++) begin
        r_bytes[i] <= 8'h00;
      end
      r_mask  <= {HDR_BYTES{1'b0}};
      r_nonce <= 32'h0000_0000;
    end else begin
      for (int i = 0; i < HDR_BYTES; i++) begin
        if (w_store && (byte_cnt == 8'(i))) begin
          r_bytes[i] <= rx_data;
        end
      end
      if (w_hdr_err) begin
        r_mask <= {HDR_BYTES{1'b0}};
      end else if (w_restart) begin
        r_mask <= w_onehot;
      end else if (w_store) begin
        r_mask <= w_mask_eff;
      end
      if (w_nonce_inc) begin
        r_nonce <= r_nonce + 32'd1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (w_store && (byte_cnt == 8'(NONCE_OFS + k))) begin
            r_nonce[8*k +: 8] <= rx_data;
          end
        end
      end
    end
  end

  // Status flags are registered off the next state so they track r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_header_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_found        <= 1'b0;
      r_exhausted    <= 1'b0;
      r_hdr_err      <= 1'b0;
    end else begin
      r_header_valid <= (w_state_nxt == ST_ISSUE);
      r_busy         <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_WAIT);
      r_found        <= (w_state_nxt == ST_FOUND);
      r_exhausted    <= (w_state_nxt == ST_EXHAUSTED);
      r_hdr_err      <= w_hdr_err;
    end
  end

  // Byte 0 sits in the top bits; the nonce overlays bytes 76..79 LSB first.
  always_comb begin
    w_header = {HDR_BITS{1'b0}};
    for (int i = 0; i < HDR_BYTES; i++) begin
      if (i >= NONCE_OFS) begin
        w_header[HDR_BITS-1-8*i -: 8] = r_nonce[8*(i-NONCE_OFS) +: 8];
      end else begin
        w_header[HDR_BITS-1-8*i -: 8] = r_bytes[i];
      end
    end
  end

  assign header_valid = r_header_valid;
  assign header       = w_header;
  assign nonce        = r_nonce;
  assign busy         = r_busy;
  assign found        = r_found;
  assign exhausted    = r_exhausted;
  assign hdr_err      = r_hdr_err;

endmodule

// File: tb/tb_header_buffer.sv
// Randomised scoreboard bench for header_buffer against a transaction-level model.
module tb_header_buffer;

  localparam logic [31:0] LIMIT = 32'h0000_0002;
  localparam int EV_ISSUE = 0;
  localparam int EV_ERR   = 1;
  localparam int EV_FOUND = 2;
  localparam int EV_EXH   = 3;

  typedef struct {
    int           kind;
    logic [639:0] hdr;
    logic [31:0]  nonce;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         write_enable;
  logic [7:0]   rx_data;
  logic [7:0]   byte_cnt;
  logic         packet_done;
  logic         hash_ready;
  logic         hash_done;
  logic         valid_hash;
  logic         header_valid;
  logic [639:0] header;
  logic [31:0]  nonce;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic         hdr_err;

  ev_t          exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  // Reference model: phase 0 collecting, 1 offered, 3 awaiting result, 2 finished.
  logic [7:0]   m_bytes [80];
  bit           m_mask  [80];
  logic [31:0]  m_nonce;
  int           m_phase;
  bit           m_found;

  bit           p_hv;
  bit           p_f;
  bit           p_x;
  logic [7:0]   pkt [80];

  always #5 clk = ~clk;

  header_buffer #(.NONCE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rx_data(rx_data),
    .byte_cnt(byte_cnt), .packet_done(packet_done), .hash_ready(hash_ready),
    .hash_done(hash_done), .valid_hash(valid_hash), .header_valid(header_valid),
    .header(header), .nonce(nonce), .busy(busy), .found(found),
    .exhausted(exhausted), .hdr_err(hdr_err)
  );

  function automatic void chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [639:0] m_header();
    logic [639:0] h;
    logic [7:0]   b;
    h = '0;
    for (int i = 0; i < 80; i++) begin
      b = (i >= 76) ? 8'(m_nonce >> (8 * (i - 76))) : m_bytes[i];
      h = {h[631:0], b};
    end
    return h;
  endfunction

  function automatic void m_push(input int kind);
    ev_t e;
    e.kind  = kind;
    e.hdr   = m_header();
    e.nonce = m_nonce;
    exp_q.push_back(e);
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 80; i++) begin
      m_bytes[i] = 8'h00;
      m_mask[i]  = 1'b0;
    end
    m_nonce = 32'h0;
    m_phase = 0;
    m_found = 1'b0;
  endfunction

  function automatic void observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d expected no event", kind);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", kind, e.kind);
    if (e.kind == EV_ISSUE) begin
      chk("issue_header", header, e.hdr);
      chk("issue_nonce", nonce, e.nonce);
    end else if (e.kind == EV_ERR) begin
      chk("err_header_valid", header_valid, 1'b0);
    end else begin
      chk("result_nonce", nonce, e.nonce);
    end
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    p_hv = 1'b0; p_f = 1'b0; p_x = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_hv = 1'b0; p_f = 1'b0; p_x = 1'b0;
      end else begin
        if (header_valid && !p_hv) observe(EV_ISSUE);
        if (hdr_err)               observe(EV_ERR);
        if (found && !p_f)         observe(EV_FOUND);
        if (exhausted && !p_x)     observe(EV_EXH);
        p_hv = header_valid; p_f = found; p_x = exhausted;
      end
    end
  end

  task automatic step(input bit we, input int cnt, input logic [7:0] d, input bit pd,
                      input bit hr, input bit hd, input bit vh);
    int       ph0;
    bit       all;
    logic [3:0] lv;
    write_enable = we; byte_cnt = cnt[7:0]; rx_data = d; packet_done = pd;
    hash_ready = hr; hash_done = hd; valid_hash = vh;
    ph0 = m_phase;
    if (we && (ph0 == 0 || ph0 == 2)) begin
      if (ph0 == 2) begin
        m_phase = 0;
        for (int i = 0; i < 80; i++) m_mask[i] = 1'b0;
      end
      if (cnt < 80) begin
        m_bytes[cnt] = d;
        m_mask[cnt]  = 1'b1;
        if (cnt >= 76) m_nonce[8*(cnt-76) +: 8] = d;
      end
    end
    if (pd && ph0 == 0) begin
      all = 1'b1;
      for (int i = 0; i < 80; i++) all = all & m_mask[i];
      if (all) begin
        m_phase = 1;
        m_push(EV_ISSUE);
      end else begin
        m_push(EV_ERR);
        for (int i = 0; i < 80; i++) m_mask[i] = 1'b0;
      end
    end
    if (hr && ph0 == 1) m_phase = 3;
    if (hd && ph0 == 3) begin
      if (vh) begin
        m_phase = 2; m_found = 1'b1; m_push(EV_FOUND);
      end else if (m_nonce == LIMIT) begin
        m_phase = 2; m_found = 1'b0; m_push(EV_EXH);
      end else begin
        m_nonce = m_nonce + 32'd1; m_phase = 1; m_push(EV_ISSUE);
      end
    end
    @(posedge clk);
    #1;
    write_enable = 1'b0; packet_done = 1'b0; hash_ready = 1'b0;
    hash_done = 1'b0; valid_hash = 1'b0;
    lv = {m_phase == 1, m_phase == 1 || m_phase == 3, m_phase == 2 && m_found, m_phase == 2 && !m_found};
    chk("levels_hv_busy_found_exh", {header_valid, busy, found, exhausted}, lv);
  endtask

  task automatic idle();
    step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_packet(input int omit, input bit shuffle, input bit pd_last);
    int order [80];
    int q [$];
    int j;
    int t;
    for (int i = 0; i < 80; i++) order[i] = i;
    if (shuffle) begin
      for (int i = 79; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
    end
    for (int i = 0; i < 80; i++) if (order[i] != omit) q.push_back(order[i]);
    for (int k = 0; k < q.size(); k++) begin
      if (shuffle && k == 40) step(1'b1, 80 + $urandom_range(175, 0), 8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, q[k], pkt[q[k]], pd_last && (k == q.size() - 1), 1'b0, 1'b0, 1'b0);
    end
    if (!pd_last) step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_hashes(input int n_invalid, input bit last_valid, input int hold, input bit noise);
    for (int a = 0; a <= n_invalid && m_phase == 1; a++) begin
      for (int h = 0; h < hold; h++) begin
        step(noise, $urandom_range(79, 0), 8'($urandom), noise, 1'b0, noise && h == 0, noise);
        chk("hold_header", header, m_header());
        chk("hold_nonce", nonce, m_nonce);
      end
      step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      if (noise) step(1'b1, $urandom_range(79, 0), 8'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1, (a == n_invalid) ? last_valid : 1'b0);
    end
  endtask

  initial begin
    write_enable = 1'b0; rx_data = 8'h00; byte_cnt = 8'h00; packet_done = 1'b0;
    hash_ready = 1'b0; hash_done = 1'b0; valid_hash = 1'b0;
    m_reset();
    rst = 1'b1;
    #12;
    chk("reset_header", header, 640'h0);
    chk("reset_nonce", nonce, 32'h0);
    chk("reset_flags", {header_valid, busy, found, exhausted, hdr_err}, 5'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle();

    // Index-valued header, then three misses and a hit with ISSUE stalls.
    for (int i = 0; i < 80; i++) pkt[i] = 8'(i);
    load_packet(-1, 1'b0, 1'b0);
    chk("hv_after_packet_done", header_valid, 1'b1);
    chk("nonce_from_bytes", nonce, 32'h4F4E4D4C);
    run_hashes(3, 1'b1, 5, 1'b1);
    chk("found_level", found, 1'b1);
    chk("found_nonce", nonce, 32'h4F4E4D4F);
    idle(); idle();

    // Byte 5 missing; packet_done rides the last write.
    load_packet(5, 1'b0, 1'b1);
    chk("hdr_err_pulse", hdr_err, 1'b1);
    idle();
    chk("hdr_err_one_cycle", hdr_err, 1'b0);

    // Complete header with packet_done on the final write.
    load_packet(-1, 1'b0, 1'b1);
    chk("hv_same_cycle_done", header_valid, 1'b1);
    run_hashes(0, 1'b1, 0, 1'b0);

    // Nonce starts at 0 and runs up to the limit.
    for (int i = 0; i < 76; i++) pkt[i] = 8'($urandom);
    for (int i = 76; i < 80; i++) pkt[i] = 8'h00;
    load_packet(-1, 1'b1, 1'b0);
    run_hashes(5, 1'b0, 1, 1'b0);
    chk("exhausted_level", exhausted, 1'b1);
    chk("exhausted_nonce", nonce, 32'h0000_0002);

    // Nonce wraps from all-ones through zero before hitting the limit.
    for (int i = 76; i < 80; i++) pkt[i] = 8'hFF;
    load_packet(-1, 1'b1, 1'b0);
    run_hashes(5, 1'b0, 0, 1'b0);
    chk("wrap_exhausted_nonce", nonce, 32'h0000_0002);

    // Reset while waiting on the hash core.
    for (int i = 0; i < 80; i++) pkt[i] = 8'($urandom);
    pkt[79] = 8'h80;
    load_packet(-1, 1'b1, 1'b0);
    step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_wait_header", header, 640'h0);
    chk("rst_wait_nonce", nonce, 32'h0);
    chk("rst_wait_flags", {header_valid, busy, found, exhausted, hdr_err}, 5'b0);
    m_reset();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    load_packet(-1, 1'b1, 1'b0);
    run_hashes(2, 1'b1, 1, 1'b1);

    // Randomised traffic.
    repeat (25) begin
      for (int i = 0; i < 80; i++) pkt[i] = 8'($urandom);
      load_packet(($urandom_range(5, 0) == 0) ? int'($urandom_range(79, 0)) : -1,
                  1'b1, 1'($urandom_range(1, 0)));
      if (m_phase == 1)
        run_hashes($urandom_range(3, 0), 1'($urandom_range(1, 0)), $urandom_range(2, 0),
                   1'($urandom_range(1, 0)));
      repeat ($urandom_range(2, 0)) idle();
    end

    repeat (3) idle();
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
